// File: rtl/window_reg_file.sv
// Windowed register file: 2-bit logical regs mapped onto NPHYS physical regs, adjacent windows overlap by half.
// Reads are combinational (zero latency); writes and window loads take effect on the next rising edge.
// No backpressure: every regWrite/ldWnd presented at an edge is accepted.
module window_reg_file #(
    parameter int WIDTH  = 16,
    parameter int NPHYS  = 8,
    parameter int LREG_W = 2,
    parameter int WND_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regWrite,
    input  logic [LREG_W-1:0] writeReg,
    input  logic [WIDTH-1:0]  writeData,
    input  logic [LREG_W-1:0] readReg1,
    input  logic [LREG_W-1:0] readReg2,
    output logic [WIDTH-1:0]  readData1,
    output logic [WIDTH-1:0]  readData2,
    input  logic              ldWnd,
    input  logic [WND_W-1:0]  wndCtrl,
    output logic [WND_W-1:0]  wndScr
);
    localparam int PHYS_W = $clog2(NPHYS);
    localparam int HALF   = (1 << LREG_W) / 2;

    logic [WIDTH-1:0] physRegs [NPHYS];
    logic [WND_W-1:0] wndPtr;

    // NPHYS is a power of two, so the modulo is just truncation to PHYS_W bits.
    function automatic logic [PHYS_W-1:0] mapReg(input logic [WND_W-1:0] wnd,
                                                 input logic [LREG_W-1:0] r);
        return PHYS_W'(wnd) * PHYS_W'(HALF) + PHYS_W'(r);
    endfunction

    logic [PHYS_W-1:0] rdIdx1, rdIdx2, wrIdx;

    assign rdIdx1    = mapReg(wndPtr, readReg1);
    assign rdIdx2    = mapReg(wndPtr, readReg2);
    assign wrIdx     = mapReg(wndPtr, writeReg);
    assign readData1 = physRegs[rdIdx1];
    assign readData2 = physRegs[rdIdx2];
    assign wndScr    = wndPtr;

    // Write index uses the pre-edge window, so a write alongside ldWnd lands in the old window.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NPHYS; i++) begin
                physRegs[i] <= '0;
            end
            wndPtr <= '0;
        end else begin
            if (regWrite) begin
                physRegs[wrIdx] <= writeData;
            end
            if (ldWnd) begin
                wndPtr <= wndCtrl;
            end
        end
    end
endmodule
